// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, Funct3
// access-size encodings and small decode helpers used by the top and the
// alignment datapath.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned BE_W  = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Funct3[1:0] selects the access size, Funct3[2] selects zero-extension.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SH  = 3'b001;
    localparam logic [F3_W-1:0] F3_SW  = 3'b010;

    localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

    // Only the five architected load encodings are accepted.
    function automatic logic load_f3_ok(input logic [F3_W-1:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Stores have no unsigned variants, so anything above sw is illegal.
    function automatic logic store_f3_ok(input logic [F3_W-1:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(input logic [F3_W-1:0] f3,
                                        input logic [1:0]      addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane datapath for the load/store unit: store byte
// enables and lane replication, load lane extraction with sign/zero
// extension. Address bits below the access size are ignored, so a
// misaligned access is treated as its naturally aligned counterpart.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [F3_W-1:0] funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    output logic [XLEN-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    // Store side: enables follow the addressed lane, data is replicated to all lanes.
    always_comb begin
        st_be_o    = BE_ALL;
        st_wdata_o = wdata_i;
        case (funct3_i[1:0])
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << addr_lo_i;
                st_wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = BE_ALL;
                st_wdata_o = wdata_i;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to a full word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_sext = ~funct3_i[2];
        case (funct3_i[1:0])
            SZ_BYTE: ld_data_o = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from the pipeline, issues a
// single word-aligned memory request held until mem_ack (or a timeout),
// and returns an extended load result / error pulse in a DONE cycle.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses
// report Err instead of being silently aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [F3_W-1:0]   Funct3,
    input  logic [XLEN-1:0]   Addr,
    input  logic [XLEN-1:0]   WrData,
    output logic              Stall,
    output logic [XLEN-1:0]   RdData,
    output logic              RdValid,
    output logic              Err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic        TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    lsu_state_e      state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [F3_W-1:0] f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic            req_any;
    logic            req_bad;
    logic            f3_bad;
    logic            mis_trap;
    logic            timeout_hit;
    logic [BE_W-1:0] st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    lsu_align u_align (
        .funct3_i   (f3_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_data_o  (ld_data)
    );

    // Decode the incoming command: anything rejected up front never reaches memory.
    always_comb begin
        req_any = MemRead | MemWrite;
        f3_bad  = MemRead ? ~load_f3_ok(Funct3) : ~store_f3_ok(Funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_trap = misaligned(Funct3, Addr[1:0]);
`else
        mis_trap = 1'b0;
`endif
        req_bad     = (MemRead & MemWrite) | f3_bad | mis_trap;
        timeout_hit = TO_EN && (cnt_q == TO_LAST);
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_any) state_d = req_bad ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state so every output is zero while in reset.
    always_comb begin
        Stall     = 1'b0;
        RdData    = '0;
        RdValid   = 1'b0;
        Err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: Stall = req_any & rst_n;
            ST_REQ: begin
                Stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                mem_be    = we_q ? st_be : BE_ALL;
                mem_wdata = we_q ? st_wdata : '0;
            end
            ST_DONE: begin
                Err     = err_q;
                RdValid = ~we_q & ~err_q;
                RdData  = (~we_q & ~err_q) ? rdata_q : '0;
            end
            default: ;
        endcase
    end

    // Control next-state: command direction, error flag and REQ cycle counter.
    always_comb begin
        we_d  = we_q;
        err_d = err_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_any) begin
                    we_d  = MemWrite & ~MemRead;
                    err_d = req_bad;
                end
            end
            ST_REQ: begin
                if (TO_EN) cnt_d = cnt_q + 32'd1;
                if (!mem_ack && timeout_hit) err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            we_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            we_q  <= we_d;
        end
    end

    // Command/data capture; these are only observed through state-gated outputs.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && req_any) begin
            f3_q    <= Funct3;
            addr_q  <= Addr;
            wdata_q <= WrData;
        end
        if (state_q == ST_REQ && mem_ack) begin
            rdata_q <= ld_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYC = 4): directed cases
// followed by randomized accesses compared against a size/offset arithmetic
// reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WrData;
    logic        Stall, RdValid, Err;
    logic [31:0] RdData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Addr      (Addr),
        .WrData    (WrData),
        .Stall     (Stall),
        .RdData    (RdData),
        .RdValid   (RdValid),
        .Err       (Err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: what one access should look like from the outside.
    task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdw, input int ack_at,
                         output bit e_err, output int e_nreq,
                         output logic [31:0] e_addr, output logic [31:0] e_be,
                         output logic [31:0] e_wd, output logic [31:0] e_rd);
        int     size;
        int     off;
        longint v;
        bit     bad;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        bad  = (rd && wr) ||
               (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
               (wr && f3 >= 3'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!bad && size > 1 && (a % size) != 0) bad = 1;
`endif
        e_addr = a - (a % 4);
        e_be = 0; e_wd = 0; e_rd = 0;
        if (bad) begin
            e_err  = 1;
            e_nreq = 0;
            return;
        end
        e_err  = (ack_at < 0 || ack_at >= TO);
        e_nreq = e_err ? TO : ack_at + 1;
        off    = int'(a % 4) - int'((a % 4) % size);
        if (wr) begin
            e_be = ((32'd1 << size) - 1) << off;
            for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
        end else begin
            e_be = 32'hF;
            v = (longint'(rdw) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (!f3[2] && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            e_rd = e_err ? 32'd0 : v[31:0];
        end
    endtask

    // Drive one command, act as memory acking in REQ cycle ack_at (<0: never), check everything.
    task automatic do_access(input string nm, input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdw, input int ack_at);
        bit          e_err;
        int          e_nreq;
        int          nreq;
        logic [31:0] e_addr, e_be, e_wd, e_rd;
        model(rd, wr, f3, a, wd, rdw, ack_at, e_err, e_nreq, e_addr, e_be, e_wd, e_rd);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
        #1 chk({nm, ".stall_idle"}, 32'(Stall), 32'd1);
        @(negedge clk);
        MemRead = 0; MemWrite = 0; Addr = $urandom; WrData = $urandom; Funct3 = 3'($urandom);
        nreq = 0;
        while (mem_req === 1'b1 && nreq < 50) begin
            chk({nm, ".req_stall"}, 32'(Stall), 32'd1);
            chk({nm, ".addr"}, mem_addr, e_addr);
            chk({nm, ".be"}, 32'(mem_be), e_be);
            chk({nm, ".we"}, 32'(mem_we), 32'(wr));
            if (wr) chk({nm, ".wdata"}, mem_wdata, e_wd);
            if (nreq == ack_at) begin
                mem_ack = 1; mem_rdata = rdw;
            end
            nreq++;
            @(negedge clk);
            mem_ack = 0; mem_rdata = $urandom;
        end
        chk({nm, ".req_cycles"}, 32'(nreq), 32'(e_nreq));
        chk({nm, ".done_stall"}, 32'(Stall), 32'd0);
        chk({nm, ".err"}, 32'(Err), 32'(e_err));
        chk({nm, ".rdvalid"}, 32'(RdValid), 32'(!wr && !e_err));
        chk({nm, ".rddata"}, RdData, e_rd);
    endtask

    initial begin
        rst_n = 0; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
        mem_ack = 0; mem_rdata = 0;
        #12;
        chk("rst.stall", 32'(Stall), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.rdvalid", 32'(RdValid), 32'd0);
        chk("rst.err", 32'(Err), 32'd0);
        chk("rst.rddata", RdData, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        do_access("sw100", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        do_access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
        do_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 1);
        do_access("sh102", 0, 1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 2);
        do_access("lw101", 1, 0, 3'b010, 32'h101, 32'h0, 32'hCAFE_F00D, 0);
        do_access("lh_hi", 1, 0, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 3);
        do_access("timeout", 1, 0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, -1);
        do_access("ld_bad", 1, 0, 3'b011, 32'h400, 32'h0, 32'h0, 0);
        do_access("st_bad", 0, 1, 3'b011, 32'h400, 32'h55, 32'h0, 0);
        do_access("both", 1, 1, 3'b010, 32'h400, 32'h55, 32'h0, 0);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        MemRead = 1; Funct3 = 3'b010; Addr = 32'h500;
        @(negedge clk);
        MemRead = 0;
        chk("midrst.req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("midrst.mem_req", 32'(mem_req), 32'd0);
        chk("midrst.stall", 32'(Stall), 32'd0);
        @(negedge clk);
        rst_n = 1;
        do_access("after_rst", 1, 0, 3'b010, 32'h504, 32'h0, 32'hA5A5_5A5A, 0);

        for (int k = 0; k < 60; k++) begin
            bit          rd, wr;
            int          aa;
            logic [2:0]  f3;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h1000 + $urandom_range(0, 255);
            aa = $urandom_range(0, 4);
            if (aa == 4) aa = -1;
            do_access("rand", rd, wr, f3, a, $urandom, $urandom, aa);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
